// File: rtl/plab5_mcore_mem_responder_if.sv
// Request/response bundle between the mcore memory arbiter (master) and the main-memory responder (slave).
// Control fields are packed MSB..LSB: req {type,opaque,addr,len}, resp {type,opaque,len}.
interface plab5_mcore_mem_responder_if #(
   parameter int p_opaque_nbits = 8,
   parameter int p_addr_nbits   = 32,
   parameter int p_data_nbits   = 32
);
   localparam int RQC = 3 + p_opaque_nbits + p_addr_nbits + 2;
   localparam int RSC = 3 + p_opaque_nbits + 2;

   logic                    req_val;
   logic                    req_rdy;
   logic [RQC-1:0]          req_control;
   logic [p_data_nbits-1:0] req_data;
   logic                    req_domain;
   logic                    resp_val;
   logic                    resp_rdy;
   logic [RSC-1:0]          resp_control;
   logic [p_data_nbits-1:0] resp_data;
   logic                    resp_insecure;
   logic                    resp_domain;

   modport master (
      output req_val, req_control, req_data, req_domain, resp_rdy,
      input  req_rdy, resp_val, resp_control, resp_data, resp_insecure, resp_domain
   );

   modport slave (
      input  req_val, req_control, req_data, req_domain, resp_rdy,
      output req_rdy, resp_val, resp_control, resp_data, resp_insecure, resp_domain
   );
endinterface

// File: rtl/plab5_mcore_mem_responder.sv
// Word-array memory responder, one transaction in flight; resp_val p_latency+1 cycles after accept, resp_* held until resp_rdy.
// Normal-domain hits in the secure window are blocked; PLAB5_MEM_RESPONDER_SCRUB_EN zeroes the array after reset.
module plab5_mcore_mem_responder #(
   parameter int                      p_opaque_nbits = 8,
   parameter int                      p_addr_nbits   = 32,
   parameter int                      p_data_nbits   = 32,
   parameter int                      p_mem_nwords   = 256,
   parameter int                      p_latency      = 2,
   parameter logic [p_addr_nbits-1:0] p_secure_base  = 'h0,
   parameter logic [p_addr_nbits-1:0] p_secure_limit = 'h3ff
) (
   input logic                         clk,
   input logic                         reset,
   plab5_mcore_mem_responder_if.slave  mem
);
   localparam int O   = p_opaque_nbits;
   localparam int A   = p_addr_nbits;
   localparam int D   = p_data_nbits;
   localparam int RQC = 3 + O + A + 2;
   localparam int RSC = 3 + O + 2;
   localparam int IDX = $clog2(p_mem_nwords);
   localparam int CW  = (p_latency > 1) ? $clog2(p_latency) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
`ifdef PLAB5_MEM_RESPONDER_SCRUB_EN
      , SCRUB = 2'd3
`endif
   } state_t;

`ifdef PLAB5_MEM_RESPONDER_SCRUB_EN
   localparam state_t RST_ST = SCRUB;
`else
   localparam state_t RST_ST = IDLE;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RQC-1:0]  ctl_q, ctl_d;
   logic [D-1:0]    wdat_q, wdat_d;
   logic            dom_q, dom_d;
   logic [RSC-1:0]  rctl_q, rctl_d;
   logic [D-1:0]    rdat_q, rdat_d;
   logic            rins_q, rins_d;
   logic            rdom_q, rdom_d;
`ifdef PLAB5_MEM_RESPONDER_SCRUB_EN
   logic [IDX-1:0]  scrub_q, scrub_d;
`endif

   logic [D-1:0]    mem_q [p_mem_nwords];
   logic            mem_we;
   logic [IDX-1:0]  mem_widx;
   logic [D-1:0]    mem_wdat;

   logic [2:0]      typ;
   logic [O-1:0]    opq;
   logic [A-1:0]    addr;
   logic [1:0]      len;
   logic [IDX-1:0]  idx;
   logic            is_wr;
   logic            blocked;
   logic [A-1:0]    addr_unused;

   assign {typ, opq, addr, len} = ctl_q;
   assign idx         = addr[IDX+1:2];
   assign addr_unused = addr;
   assign is_wr       = (typ == 3'd1);
   // Offset compare keeps the window check a single unsigned range test, valid for base <= limit.
   assign blocked     = !dom_q && ((addr - p_secure_base) <= (p_secure_limit - p_secure_base));

   assign mem.req_rdy       = reset && (state_q == IDLE);
   assign mem.resp_val      = (state_q == RESP);
   assign mem.resp_control  = rctl_q;
   assign mem.resp_data     = rdat_q;
   assign mem.resp_insecure = rins_q;
   assign mem.resp_domain   = rdom_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ctl_d    = ctl_q;
      wdat_d   = wdat_q;
      dom_d    = dom_q;
      rctl_d   = rctl_q;
      rdat_d   = rdat_q;
      rins_d   = rins_q;
      rdom_d   = rdom_q;
      mem_we   = 1'b0;
      mem_widx = idx;
      mem_wdat = wdat_q;
`ifdef PLAB5_MEM_RESPONDER_SCRUB_EN
      scrub_d  = scrub_q;
`endif
      case (state_q)
         IDLE: begin
            if (mem.req_val) begin
               ctl_d   = mem.req_control;
               wdat_d  = mem.req_data;
               dom_d   = mem.req_domain;
               cnt_d   = CW'(p_latency - 1);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               mem_we  = is_wr && !blocked;
               rctl_d  = {typ, opq, len};
               rdat_d  = (is_wr || blocked) ? '0 : mem_q[idx];
               rins_d  = blocked;
               rdom_d  = dom_q;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (mem.resp_rdy) state_d = IDLE;
         end
`ifdef PLAB5_MEM_RESPONDER_SCRUB_EN
         SCRUB: begin
            mem_we   = 1'b1;
            mem_widx = scrub_q;
            mem_wdat = '0;
            scrub_d  = scrub_q + IDX'(1);
            if (scrub_q == IDX'(p_mem_nwords - 1)) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RST_ST;
         cnt_q   <= '0;
         ctl_q   <= '0;
         wdat_q  <= '0;
         dom_q   <= 1'b0;
         rctl_q  <= '0;
         rdat_q  <= '0;
         rins_q  <= 1'b0;
         rdom_q  <= 1'b0;
`ifdef PLAB5_MEM_RESPONDER_SCRUB_EN
         scrub_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctl_q   <= ctl_d;
         wdat_q  <= wdat_d;
         dom_q   <= dom_d;
         rctl_q  <= rctl_d;
         rdat_q  <= rdat_d;
         rins_q  <= rins_d;
         rdom_q  <= rdom_d;
`ifdef PLAB5_MEM_RESPONDER_SCRUB_EN
         scrub_q <= scrub_d;
`endif
      end
   end

   // Array has no reset and keeps its contents through reset; it may also be initialised externally.
   always @(posedge clk) begin
      if (mem_we && reset) mem_q[mem_widx] <= mem_wdat;
   end
endmodule
